// File: rtl/rom_scan_controller.sv
// ROM scan sequencer: walks ROM addresses, issues reads, waits the ROM latency and
// presents each word as a latched value plus a 7-segment hex glyph.
module rom_scan_controller #(
  parameter int ADDR_WIDTH   = 2,
  parameter int DATA_WIDTH   = 4,
  parameter int ROM_LATENCY  = 1,
  parameter int DWELL_CYCLES = 4
) (
  input  logic                  clk_2,
  input  logic                  reset,
  input  logic                  auto_mode,
  input  logic                  run,
  input  logic                  step,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  output logic                  rom_rd,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic [7:0]            seg,
  output logic                  busy,
  output logic                  wrap
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_SHOW  = 2'd3
  } state_t;

  localparam int WAIT_W  = $clog2(ROM_LATENCY + 1);
  localparam int DWELL_W = $clog2(DWELL_CYCLES + 1);
  localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(ROM_LATENCY - 1);
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);

  state_t             state;
  state_t             state_next;
  logic [WAIT_W-1:0]  wait_cnt;
  logic [DWELL_W-1:0] dwell_cnt;
  logic               wait_done;
  logic               dwell_done;
  logic               show_exit;

  function automatic logic [7:0] hex_glyph(input logic [3:0] digit);
    logic [7:0] pattern;
    case (digit)
      4'h0: pattern = 8'h3F;
      4'h1: pattern = 8'h06;
      4'h2: pattern = 8'h5B;
      4'h3: pattern = 8'h4F;
      4'h4: pattern = 8'h66;
      4'h5: pattern = 8'h6D;
      4'h6: pattern = 8'h7D;
      4'h7: pattern = 8'h07;
      4'h8: pattern = 8'h7F;
      4'h9: pattern = 8'h6F;
      4'hA: pattern = 8'h77;
      4'hB: pattern = 8'h7C;
      4'hC: pattern = 8'h39;
      4'hD: pattern = 8'h5E;
      4'hE: pattern = 8'h79;
      default: pattern = 8'h71;
    endcase
    return pattern;
  endfunction

  assign wait_done  = (state == ST_WAIT) && (wait_cnt == WAIT_LAST);
  assign dwell_done = (dwell_cnt == DWELL_LAST);
  // Mode is looked at live in SHOW, so a mode change during a read only matters here.
  assign show_exit  = (state == ST_SHOW) && (auto_mode ? dwell_done : step);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_2) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    // NOTE: default first so no path leaves state_next unassigned and infers a latch.
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (auto_mode ? run : step) state_next = ST_ISSUE;
      end
      ST_ISSUE: state_next = ST_WAIT;
      ST_WAIT: begin
        if (wait_done) state_next = ST_SHOW;
      end
      ST_SHOW: begin
        if (show_exit) begin
          state_next = (auto_mode && !run) ? ST_IDLE : ST_ISSUE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    rom_rd = (state == ST_ISSUE);
    busy   = (state != ST_IDLE);
  end

  // NOTE: every datapath register is reset because outputs must blank immediately on reset.
  always_ff @(posedge clk_2) begin
    if (reset) begin
      rom_addr   <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      seg        <= 8'h00;
      wrap       <= 1'b0;
      wait_cnt   <= '0;
      dwell_cnt  <= '0;
    end else begin
      data_valid <= 1'b0;
      wrap       <= 1'b0;

      if (wait_done) begin
        data_out   <= rom_data;
        seg        <= hex_glyph(4'(rom_data));
        data_valid <= 1'b1;
      end

      if (show_exit) begin
        rom_addr <= rom_addr + ADDR_WIDTH'(1);
        wrap     <= &rom_addr;
      end

      if ((state == ST_WAIT) && !wait_done) begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end else begin
        wait_cnt <= '0;
      end

      // Dwell count saturates so a long manual hold cannot wrap it.
      if ((state == ST_SHOW) && !show_exit) begin
        if (!dwell_done) dwell_cnt <= dwell_cnt + DWELL_W'(1);
      end else begin
        dwell_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_rom_scan_controller.sv
// Bench for rom_scan_controller: two instances (default timing and latency 3 / dwell 1),
// each fed by a latency-accurate ROM model and checked cycle by cycle against a timeline model.
module tb_rom_scan_controller;

  localparam int LAT_A = 1;
  localparam int DW_A  = 4;
  localparam int LAT_B = 3;
  localparam int DW_B  = 1;

  localparam logic [7:0] GLYPH [16] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
    8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
  };

  typedef struct packed {
    logic [1:0] addr;
    logic       rd;
    logic [3:0] dout;
    logic       dv;
    logic [7:0] seg;
    logic       busy;
    logic       wrap;
  } obs_t;

  logic clk_2 = 1'b0;
  always #5 clk_2 = ~clk_2;

  logic       a_reset, a_auto, a_run, a_step;
  logic [1:0] a_rom_addr;
  logic       a_rom_rd;
  logic [3:0] a_rom_data;
  logic [3:0] a_data_out;
  logic       a_dv;
  logic [7:0] a_seg;
  logic       a_busy, a_wrap;

  logic       b_reset, b_auto, b_run, b_step;
  logic [1:0] b_rom_addr;
  logic       b_rom_rd;
  logic [3:0] b_rom_data;
  logic [3:0] b_data_out;
  logic       b_dv;
  logic [7:0] b_seg;
  logic       b_busy, b_wrap;

  rom_scan_controller #(
    .ADDR_WIDTH(2), .DATA_WIDTH(4), .ROM_LATENCY(LAT_A), .DWELL_CYCLES(DW_A)
  ) dut_a (
    .clk_2(clk_2), .reset(a_reset), .auto_mode(a_auto), .run(a_run), .step(a_step),
    .rom_addr(a_rom_addr), .rom_rd(a_rom_rd), .rom_data(a_rom_data),
    .data_out(a_data_out), .data_valid(a_dv), .seg(a_seg), .busy(a_busy), .wrap(a_wrap)
  );

  rom_scan_controller #(
    .ADDR_WIDTH(2), .DATA_WIDTH(4), .ROM_LATENCY(LAT_B), .DWELL_CYCLES(DW_B)
  ) dut_b (
    .clk_2(clk_2), .reset(b_reset), .auto_mode(b_auto), .run(b_run), .step(b_step),
    .rom_addr(b_rom_addr), .rom_rd(b_rom_rd), .rom_data(b_rom_data),
    .data_out(b_data_out), .data_valid(b_dv), .seg(b_seg), .busy(b_busy), .wrap(b_wrap)
  );

  // ROM models: the word is valid only exactly LAT cycles after the read; otherwise junk.
  logic [3:0] mem_a [4];
  logic [3:0] mem_b [4];
  logic       a_v;
  logic [1:0] a_ra;
  logic [2:0] b_v;
  logic [1:0] b_ra [3];

  always @(posedge clk_2) begin
    a_v     <= a_rom_rd;
    a_ra    <= a_rom_addr;
    b_v     <= {b_v[1:0], b_rom_rd};
    b_ra[0] <= b_rom_addr;
    b_ra[1] <= b_ra[0];
    b_ra[2] <= b_ra[1];
  end

  assign a_rom_data = a_v    ? mem_a[a_ra]    : ~mem_a[a_ra];
  assign b_rom_data = b_v[2] ? mem_b[b_ra[2]] : ~mem_b[b_ra[2]];

  int total = 0;
  int bad   = 0;

  initial begin
    #5_000_000;
    $display("FAIL timeout: bench did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_obs(input string tag, input obs_t o, input obs_t e);
    chk({tag, ".addr"}, 32'(o.addr), 32'(e.addr));
    chk({tag, ".rd"},   32'(o.rd),   32'(e.rd));
    chk({tag, ".dout"}, 32'(o.dout), 32'(e.dout));
    chk({tag, ".dv"},   32'(o.dv),   32'(e.dv));
    chk({tag, ".seg"},  32'(o.seg),  32'(e.seg));
    chk({tag, ".busy"}, 32'(o.busy), 32'(e.busy));
    chk({tag, ".wrap"}, 32'(o.wrap), 32'(e.wrap));
  endtask

  task automatic tick();
    @(posedge clk_2);
    #1;
  endtask

  function automatic obs_t sample(input bit sel);
    obs_t o;
    if (sel) o = '{b_rom_addr, b_rom_rd, b_data_out, b_dv, b_seg, b_busy, b_wrap};
    else     o = '{a_rom_addr, a_rom_rd, a_data_out, a_dv, a_seg, a_busy, a_wrap};
    return o;
  endfunction

  task automatic set_in(input bit sel, input logic rst, input logic au, input logic rn,
                        input logic st);
    if (sel) begin
      b_reset = rst; b_auto = au; b_run = rn; b_step = st;
    end else begin
      a_reset = rst; a_auto = au; a_run = rn; a_step = st;
    end
  endtask

  function automatic int lat(input bit sel);
    return sel ? LAT_B : LAT_A;
  endfunction

  function automatic int period(input bit sel);
    return sel ? (1 + LAT_B + DW_B) : (1 + LAT_A + DW_A);
  endfunction

  function automatic logic [3:0] memv(input bit sel, input int idx);
    return sel ? mem_b[idx % 4] : mem_a[idx % 4];
  endfunction

  // Word index cur is the last word captured (-1: nothing captured since reset).
  function automatic obs_t shown(input bit sel, input int cur, input obs_t e_in);
    obs_t e = e_in;
    if (cur < 0) begin
      e.dout = 4'h0;
      e.seg  = 8'h00;
    end else begin
      e.dout = memv(sel, cur);
      e.seg  = GLYPH[memv(sel, cur)];
    end
    return e;
  endfunction

  // Auto scan timeline: word k is read at cycle 1 + k*P; run drops during the last of n words.
  function automatic obs_t auto_exp(input bit sel, input int c, input int n);
    obs_t e = '0;
    int p = period(sel);
    int l = lat(sel);
    int k = (c - 1) / p;
    int ph = (c - 1) % p;
    int cur;
    if (k < n) begin
      e.busy = 1'b1;
      e.rd   = (ph == 0);
      e.addr = 2'(k % 4);
      e.dv   = (ph == 1 + l);
      e.wrap = (ph == 0) && (k > 0) && (k % 4 == 0);
      cur    = (ph >= 1 + l) ? k : k - 1;
    end else begin
      e.addr = 2'(n % 4);
      e.wrap = (c - 1 == n * p) && (n % 4 == 0);
      cur    = n - 1;
    end
    return shown(sel, cur, e);
  endfunction

  task automatic do_reset(input bit sel, input logic au, input string tag);
    set_in(sel, 1'b1, au, 1'b0, 1'b0);
    tick();
    tick();
    set_in(sel, 1'b0, au, 1'b0, 1'b0);
    chk_obs({tag, ".rst"}, sample(sel), '0);
  endtask

  task automatic auto_run(input bit sel, input int n, input int drop_ph, input string tag);
    int p = period(sel);
    do_reset(sel, 1'b1, tag);
    set_in(sel, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int c = 1; c <= n * p + 4; c++) begin
      tick();
      chk_obs($sformatf("%s.c%0d", tag, c), sample(sel), auto_exp(sel, c, n));
      if (c - 1 == (n - 1) * p + drop_ph) set_in(sel, 1'b0, 1'b1, 1'b0, 1'b0);
    end
  endtask

  // Manual: accepted steps at s[j]; a stray step lands in the WAIT after step 1.
  task automatic manual_run(input bit sel, input int n, input string tag);
    int l = lat(sel);
    int s[$];
    int last_t;
    int spur;
    do_reset(sel, 1'b0, tag);
    set_in(sel, 1'b0, 1'b0, 1'b1, 1'b0);
    s.push_back(3);
    for (int i = 1; i < n; i++) s.push_back(s[i-1] + int'($urandom_range(l + 8, l + 2)));
    spur   = s[1] + 2;
    last_t = s[n-1] + l + 6;
    for (int t = 0; t <= last_t; t++) begin
      obs_t e = '0;
      int j = -1;
      logic st;
      if (t > 0) tick();
      foreach (s[i]) if (s[i] < t) j = i;
      if (j >= 0) begin
        int rel = t - s[j];
        e.busy = 1'b1;
        e.rd   = (rel == 1);
        e.addr = 2'(j % 4);
        e.dv   = (rel == 2 + l);
        e.wrap = (rel == 1) && (j > 0) && (j % 4 == 0);
        e = shown(sel, (rel >= 2 + l) ? j : j - 1, e);
      end
      chk_obs($sformatf("%s.t%0d", tag, t), sample(sel), e);
      st = (t == spur);
      foreach (s[i]) if (s[i] == t) st = 1'b1;
      set_in(sel, 1'b0, 1'b0, 1'b1, st);
    end
  endtask

  task automatic reset_mid(input bit sel, input string tag);
    obs_t e = '0;
    auto_run(sel, 1, 1 + lat(sel), tag);
    set_in(sel, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    e.addr = 2'd1; e.rd = 1'b1; e.busy = 1'b1;
    e = shown(sel, 0, e);
    chk_obs({tag, ".issue"}, sample(sel), e);
    tick();
    e.rd = 1'b0;
    chk_obs({tag, ".wait"}, sample(sel), e);
    set_in(sel, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    chk_obs({tag, ".abort"}, sample(sel), '0);
    set_in(sel, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_obs($sformatf("%s.after%0d", tag, i), sample(sel), '0);
    end
  endtask

  task automatic load_mem(input bit sel, input bit rnd);
    for (int i = 0; i < 4; i++) begin
      logic [3:0] v;
      case (i)
        0: v = 4'h6;
        1: v = 4'hC;
        2: v = 4'h9;
        default: v = 4'h5;
      endcase
      if (rnd) v = 4'($urandom_range(15, 0));
      if (sel) mem_b[i] = v;
      else     mem_a[i] = v;
    end
  endtask

  initial begin
    set_in(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    set_in(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    load_mem(1'b0, 1'b0);
    load_mem(1'b1, 1'b0);

    auto_run(1'b0, 5, 1 + LAT_A, "A.auto5");
    auto_run(1'b0, 2, 3, "A.rundrop");
    manual_run(1'b0, 3, "A.manual");
    reset_mid(1'b0, "A.rstwait");

    auto_run(1'b1, 5, 1 + LAT_B, "B.auto5");
    manual_run(1'b1, 5, "B.manual");
    reset_mid(1'b1, "B.rstwait");

    for (int it = 0; it < 3; it++) begin
      load_mem(1'b0, 1'b1);
      load_mem(1'b1, 1'b1);
      auto_run(1'b0, int'($urandom_range(6, 1)), int'($urandom_range(1 + LAT_A + DW_A - 1, 1 + LAT_A)),
               $sformatf("A.rnd%0d", it));
      manual_run(1'b0, int'($urandom_range(6, 2)), $sformatf("A.rman%0d", it));
      auto_run(1'b1, int'($urandom_range(6, 1)), 1 + LAT_B, $sformatf("B.rnd%0d", it));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
